keypad_mult_ctrl: RTL and testbench



---
 rtl/keypad_mult_pkg.sv | 15 +
 rtl/keypad_mult_ctrl_shift_add.sv | 58 +++++
 rtl/keypad_mult_ctrl.sv | 146 ++++++++++++++
 tb/tb_keypad_mult_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_mult_pkg.sv
// Shared encodings for the keypad multiplier controller: FSM states and key codes.
package keypad_mult_pkg;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    MULT    = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [3:0] KEY_ENTER     = 4'hE;
  localparam logic [3:0] KEY_CLEAR     = 4'hF;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;

endpackage

// File: rtl/keypad_mult_ctrl_shift_add.sv
// Sequential shift-add multiplier: one multiplier bit per clock, done pulses in
// the OPW-th cycle after start with the finished product on p in that cycle.
module shift_add_mult
  import keypad_mult_pkg::*;
#(
  parameter int OPW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic             done,
  output logic [2*OPW-1:0] p
);

  localparam int PW = 2 * OPW;
  localparam int CW = $clog2(OPW + 1);

  logic          run_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] mcand_q;
  logic [OPW-1:0] mplier_q;
  logic [PW-1:0] acc_q;
  logic [PW-1:0] acc_d;

  // p exposes the accumulation of the current bit so the final sum is
  // available in the same cycle as done.
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done  = run_q && (cnt_q == CW'(1));
  assign p     = acc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= CW'(OPW);
    end else if (run_q) begin
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      mcand_q  <= PW'(a);
      mplier_q <= b;
      acc_q    <= '0;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/keypad_mult_ctrl.sv
// Keypad-driven decimal operand entry and multiply controller.
// KEYPAD_MULT_SEQ_EN selects the OPW-cycle shift-add engine; otherwise MULT is one cycle.
module keypad_mult_ctrl
  import keypad_mult_pkg::*;
#(
  parameter int OPW  = 8,
  parameter int MAXD = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [OPW-1:0]   op_a,
  output logic [OPW-1:0]   op_b,
  output logic [2*OPW-1:0] product,
  output logic             prod_valid,
  output logic             busy,
  output logic [1:0]       state
);

  localparam int PW = 2 * OPW;
  localparam int EW = OPW + 4;
  localparam int DW = $clog2(MAXD + 1);

  state_e          state_q;
  logic [OPW-1:0]  op_a_q, op_b_q;
  logic [PW-1:0]   product_q;
  logic            prod_valid_q, busy_q;
  logic [DW-1:0]   digits_q;

  logic            is_digit;
  logic [OPW-1:0]  cur_op;
  logic [EW-1:0]   scaled_d;
  logic            digit_ok;
  logic            start_mult;

  assign is_digit = (key_code <= KEY_DIGIT_MAX);
  assign cur_op   = (state_q == ENTER_B) ? op_b_q : op_a_q;
  // Widened by 4 bits so op*10+d cannot wrap before the range test.
  assign scaled_d = EW'(cur_op) * EW'(10) + EW'(key_code);
  assign digit_ok = (digits_q < DW'(MAXD)) && (scaled_d[EW-1:OPW] == '0);
  assign start_mult = key_valid && (state_q == ENTER_B) && (key_code == KEY_ENTER);

`ifdef KEYPAD_MULT_SEQ_EN
  logic          mult_done;
  logic [PW-1:0] mult_p;

  shift_add_mult #(.OPW(OPW)) u_mult (
    .clk   (clk),
    .reset (reset),
    .start (start_mult),
    .a     (op_a_q),
    .b     (op_b_q),
    .done  (mult_done),
    .p     (mult_p)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ENTER_A;
      op_a_q       <= '0;
      op_b_q       <= '0;
      product_q    <= '0;
      prod_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      digits_q     <= '0;
    end else begin
      unique case (state_q)
        ENTER_A: if (key_valid) begin
          if (is_digit) begin
            if (digit_ok) begin
              op_a_q   <= scaled_d[OPW-1:0];
              digits_q <= digits_q + DW'(1);
            end
          end else if (key_code == KEY_ENTER) begin
            state_q  <= ENTER_B;
            digits_q <= '0;
          end else if (key_code == KEY_CLEAR) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            digits_q <= '0;
          end
        end
        ENTER_B: if (key_valid) begin
          if (is_digit) begin
            if (digit_ok) begin
              op_b_q   <= scaled_d[OPW-1:0];
              digits_q <= digits_q + DW'(1);
            end
          end else if (start_mult) begin
            state_q <= MULT;
            busy_q  <= 1'b1;
          end else if (key_code == KEY_CLEAR) begin
            state_q  <= ENTER_A;
            op_a_q   <= '0;
            op_b_q   <= '0;
            digits_q <= '0;
          end
        end
        // Keys are deliberately ignored here; product is written only once complete.
        MULT: begin
`ifdef KEYPAD_MULT_SEQ_EN
          if (mult_done) begin
            product_q    <= mult_p;
            state_q      <= DONE;
            busy_q       <= 1'b0;
            prod_valid_q <= 1'b1;
          end
`else
          product_q    <= PW'(op_a_q) * PW'(op_b_q);
          state_q      <= DONE;
          busy_q       <= 1'b0;
          prod_valid_q <= 1'b1;
`endif
        end
        DONE: if (key_valid) begin
          if (key_code == KEY_CLEAR) begin
            state_q      <= ENTER_A;
            op_a_q       <= '0;
            op_b_q       <= '0;
            product_q    <= '0;
            prod_valid_q <= 1'b0;
            digits_q     <= '0;
          end else if (is_digit) begin
            // Chained entry: the digit starts a fresh operand A.
            state_q      <= ENTER_A;
            op_a_q       <= OPW'(key_code);
            op_b_q       <= '0;
            product_q    <= '0;
            prod_valid_q <= 1'b0;
            digits_q     <= DW'(1);
          end
        end
      endcase
    end
  end

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign product    = product_q;
  assign prod_valid = prod_valid_q;
  assign busy       = busy_q;
  assign state      = state_q;

endmodule

// File: tb/tb_keypad_mult_ctrl.sv
// Scoreboard bench for keypad_mult_ctrl: directed key sequences, products checked on prod_valid.
module tb_keypad_mult_ctrl;

  localparam int OPW  = 8;
  localparam int MAXD = 3;
`ifdef KEYPAD_MULT_SEQ_EN
  localparam int LAT   = OPW + 1;
  localparam int BUSYC = OPW;
`else
  localparam int LAT   = 2;
  localparam int BUSYC = 1;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             key_valid;
  logic [3:0]       key_code;
  logic [OPW-1:0]   op_a, op_b;
  logic [2*OPW-1:0] product;
  logic             prod_valid, busy;
  logic [1:0]       state;

  keypad_mult_ctrl #(.OPW(OPW), .MAXD(MAXD)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .op_a       (op_a),
    .op_b       (op_b),
    .product    (product),
    .prod_valid (prod_valid),
    .busy       (busy),
    .state      (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned prod;
    int unsigned a;
    int unsigned b;
    int          start;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic key(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      key_valid = 1'b0;
    end
  endtask

  // Final ENTER of an entry: the expected result is queued at issue time.
  task automatic enter_expect(input int unsigned p, input int unsigned a, input int unsigned b);
    key(4'hE);
    sb.push_back('{prod: p, a: a, b: b, start: cyc});
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    idle(1);
    while (!prod_valid && n < 40) begin
      idle(1);
      n++;
    end
    checks++;
    if (!prod_valid) begin
      fails++;
      $display("FAIL %s_timeout: got prod_valid=0 expected 1", name);
    end
  endtask

  // Monitor: pops and compares on every prod_valid rising edge.
  initial begin
    int  busy_cnt = 0;
    logic pv_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt = 0;
        pv_prev  = 1'b0;
      end else begin
        if (busy) busy_cnt++;
        if (prod_valid && !pv_prev) begin
          if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_result: got product=%0d expected no result", product);
          end else begin
            e = sb.pop_front();
            chk("product", product, e.prod);
            chk("done_op_a", op_a, e.a);
            chk("done_op_b", op_b, e.b);
            chk("latency", cyc - e.start, LAT);
            chk("busy_cycles", busy_cnt, BUSYC);
          end
          busy_cnt = 0;
        end
        pv_prev = prod_valid;
      end
    end
  end

  task automatic chk_idle_zero(input string name);
    chk({name, "_state"}, state, 0);
    chk({name, "_op_a"}, op_a, 0);
    chk({name, "_op_b"}, op_b, 0);
    chk({name, "_product"}, product, 0);
    chk({name, "_prod_valid"}, prod_valid, 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  initial begin
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_idle_zero("reset");

    // 12 x 11 with back-to-back keys
    key(4'h1); key(4'h2); key(4'hE); key(4'h1); key(4'h1);
    idle(1);
    chk("entry_op_a", op_a, 12);
    chk("entry_op_b", op_b, 11);
    chk("entry_state", state, 1);
    enter_expect(132, 12, 11);
    wait_done("t132");
    key(4'hF); idle(1);
    chk_idle_zero("clear_done");

    // Max operands: 255 x 255
    key(4'h2); key(4'h5); key(4'h5); key(4'hE);
    key(4'h2); key(4'h5); key(4'h5);
    enter_expect(65025, 255, 255);
    wait_done("t65025");
    key(4'hE); idle(1);
    chk("enter_in_done_state", state, 3);
    chk("enter_in_done_pv", prod_valid, 1);
    chk("enter_in_done_product", product, 65025);
    key(4'hF); idle(1);

    // Overflow rejection: 256 does not fit
    key(4'h2); key(4'h5); key(4'h6); idle(1);
    chk("overflow_op_a", op_a, 25);
    key(4'hF);

    // Digit limit
    key(4'h1); key(4'h2); key(4'h3); key(4'h4); idle(1);
    chk("maxd_op_a", op_a, 123);
    key(4'hF);

    // Ignored code, then CLEAR from ENTER_B
    key(4'h7); key(4'hA); idle(1);
    chk("ignored_key_op_a", op_a, 7);
    key(4'hE); key(4'hF); idle(1);
    chk("clear_b_state", state, 0);
    chk("clear_b_op_a", op_a, 0);

    // Empty operands
    key(4'hE);
    enter_expect(0, 0, 0);
    wait_done("tzero");
    key(4'hF);

    // CLEAR during MULT is ignored
    key(4'h3); key(4'hE); key(4'h4);
    enter_expect(12, 3, 4);
    key(4'hF);
    wait_done("t12");

    // Chained entry from DONE
    key(4'h5); idle(1);
    chk("chain_pv", prod_valid, 0);
    chk("chain_state", state, 0);
    chk("chain_op_a", op_a, 5);
    chk("chain_op_b", op_b, 0);
    chk("chain_product", product, 0);
    key(4'hF);

    // Reset while multiplying
    key(4'h5); key(4'hE); key(4'h5); key(4'hE);
    idle(1);
`ifdef KEYPAD_MULT_SEQ_EN
    idle(2);
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle_zero("mid_mult_reset");

    key(4'h9); key(4'hE); key(4'h9);
    enter_expect(81, 9, 9);
    wait_done("t81");

    idle(4);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
